// File: rtl/mem_ws_slave.sv
// ---------------------------------------------------------------------------
// mem_ws_slave
//   Word-addressed memory slave with a fixed number of wait states per
//   transfer and byte-enabled writes. One transfer is in flight at a time.
//   Out-of-range addresses complete normally but flag err, drop the write
//   and return zero read data. Completed writes and reads are counted with
//   saturating 16-bit counters.
//
// Ports
//   clk     in   clock, all logic on posedge
//   res     in   asynchronous active-high reset
//   wr_rd   in   1 = write, 0 = read
//   addr    in   word address            [ADDR_WIDTH-1:0]
//   wdata   in   write data              [WIDTH-1:0]
//   wstrb   in   byte enables for writes [WIDTH/8-1:0]
//   valid   in   request valid, sampled in IDLE only
//   ready   out  one-cycle completion pulse
//   rdata   out  read data, zero whenever ready is low
//   err     out  out-of-range address, qualified by ready
//   wr_cnt  out  completed writes (saturating)
//   rd_cnt  out  completed reads (saturating)
//
// State | meaning
// ------+------------------------------------------------------------
// IDLE  | waiting for valid; captures the request on the valid edge
// WAIT  | counting down the wait states
// RESP  | ready high for one cycle; write commits on the exiting edge
// ---------------------------------------------------------------------------
module mem_ws_slave #(
    parameter int WIDTH       = 32,
    parameter int ADDR_WIDTH  = 5,
    parameter int DEPTH       = 16,
    parameter int WAIT_STATES = 2
) (
    input  logic                  clk,
    input  logic                  res,
    input  logic                  wr_rd,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [WIDTH-1:0]      wdata,
    input  logic [WIDTH/8-1:0]    wstrb,
    input  logic                  valid,
    output logic                  ready,
    output logic [WIDTH-1:0]      rdata,
    output logic                  err,
    output logic [15:0]           wr_cnt,
    output logic [15:0]           rd_cnt
);

    localparam int NB    = WIDTH / 8;
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int WS_M1 = (WAIT_STATES > 0) ? WAIT_STATES - 1 : 0;

    localparam logic [3:0]            WS_LOAD = 4'(WS_M1);
    localparam logic [ADDR_WIDTH:0]   DEPTH_L = (ADDR_WIDTH + 1)'(DEPTH);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    logic [1:0]            r_state;
    logic [3:0]            r_wcnt;
    logic                  r_wr;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [WIDTH-1:0]      r_wdata;
    logic [NB-1:0]         r_wstrb;
    logic                  r_ready;
    logic [WIDTH-1:0]      r_rdata;
    logic                  r_err;
    logic [15:0]           r_wr_cnt;
    logic [15:0]           r_rd_cnt;

    logic [WIDTH-1:0]      r_mem [DEPTH];

    logic [ADDR_WIDTH-1:0] w_sel_addr;
    logic                  w_sel_wr;
    logic                  w_in_range;
    logic [IDX_W-1:0]      w_idx;
    logic [WIDTH-1:0]      w_rd_word;
    logic                  w_enter_resp;
    logic                  w_mem_we;

    // With zero wait states RESP is entered on the capture edge itself, so
    // the response must be computed from the live inputs in that case.
    assign w_sel_addr = (r_state == S_IDLE) ? addr  : r_addr;
    assign w_sel_wr   = (r_state == S_IDLE) ? wr_rd : r_wr;
    assign w_in_range = ({1'b0, w_sel_addr} < DEPTH_L);
    assign w_idx      = w_sel_addr[IDX_W-1:0];
    assign w_rd_word  = w_in_range ? r_mem[w_idx] : '0;

    assign w_enter_resp = ((r_state == S_IDLE) && valid && (WAIT_STATES == 0)) ||
                          ((r_state == S_WAIT) && (r_wcnt == 4'd0));

    // In RESP the selected address is the captured one.
    assign w_mem_we = (r_state == S_RESP) && r_wr && w_in_range;

    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            r_state  <= S_IDLE;
            r_wcnt   <= 4'd0;
            r_wr     <= 1'b0;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_wstrb  <= '0;
            r_ready  <= 1'b0;
            r_rdata  <= '0;
            r_err    <= 1'b0;
            r_wr_cnt <= 16'd0;
            r_rd_cnt <= 16'd0;
        end else begin
            // Response outputs live for exactly the RESP cycle.
            r_ready <= w_enter_resp;
            r_err   <= w_enter_resp && !w_in_range;
            r_rdata <= (w_enter_resp && !w_sel_wr) ? w_rd_word : '0;

            case (r_state)
                S_IDLE: begin
                    if (valid) begin
                        r_wr    <= wr_rd;
                        r_addr  <= addr;
                        r_wdata <= wdata;
                        r_wstrb <= wstrb;
                        if (WAIT_STATES > 0) begin
                            r_state <= S_WAIT;
                            r_wcnt  <= WS_LOAD;
                        end else begin
                            r_state <= S_RESP;
                        end
                    end
                end
                S_WAIT: begin
                    if (r_wcnt == 4'd0) begin
                        r_state <= S_RESP;
                    end else begin
                        r_wcnt <= r_wcnt - 4'd1;
                    end
                end
                S_RESP: begin
                    r_state <= S_IDLE;
                    if (r_wr) begin
                        if (r_wr_cnt != 16'hFFFF) r_wr_cnt <= r_wr_cnt + 16'd1;
                    end else begin
                        if (r_rd_cnt != 16'hFFFF) r_rd_cnt <= r_rd_cnt + 16'd1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Memory contents survive reset; reset only aborts the pending commit
    // because the state is forced out of RESP.
    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            for (int b = 0; b < NB; b++) begin
                if (r_wstrb[b]) begin
                    r_mem[w_idx][8*b +: 8] <= r_wdata[8*b +: 8];
                end
            end
        end
    end

    assign ready  = r_ready;
    assign rdata  = r_rdata;
    assign err    = r_err;
    assign wr_cnt = r_wr_cnt;
    assign rd_cnt = r_rd_cnt;

endmodule

// File: tb/tb_mem_ws_slave.sv
module tb_mem_ws_slave;

    typedef struct {
        logic        wr;
        logic [4:0]  addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic [31:0] rdata;
        logic        err;
    } vec_t;

    typedef struct {
        logic        wr;
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    logic        clk;
    logic        res;
    logic        wr_rd;
    logic [4:0]  addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        valid0, valid1;
    logic        ready0, ready1;
    logic [31:0] rdata0, rdata1;
    logic        err0, err1;
    logic [15:0] wr_cnt0, wr_cnt1, rd_cnt0, rd_cnt1;

    logic        sel;
    logic        ready_s, err_s;
    logic [31:0] rdata_s;
    logic [15:0] wr_cnt_s, rd_cnt_s;

    int          n_pass = 0;
    int          n_tot  = 0;
    int          cyc    = 0;
    logic [15:0] mw [2];
    logic [15:0] mr [2];
    exp_t        q[$];
    vec_t        vecs [17];

    mem_ws_slave #(.WIDTH(32), .ADDR_WIDTH(5), .DEPTH(16), .WAIT_STATES(2)) dut0 (
        .clk(clk), .res(res), .wr_rd(wr_rd), .addr(addr), .wdata(wdata),
        .wstrb(wstrb), .valid(valid0), .ready(ready0), .rdata(rdata0),
        .err(err0), .wr_cnt(wr_cnt0), .rd_cnt(rd_cnt0)
    );

    mem_ws_slave #(.WIDTH(32), .ADDR_WIDTH(5), .DEPTH(16), .WAIT_STATES(0)) dut1 (
        .clk(clk), .res(res), .wr_rd(wr_rd), .addr(addr), .wdata(wdata),
        .wstrb(wstrb), .valid(valid1), .ready(ready1), .rdata(rdata1),
        .err(err1), .wr_cnt(wr_cnt1), .rd_cnt(rd_cnt1)
    );

    always_comb begin
        ready_s  = sel ? ready1  : ready0;
        err_s    = sel ? err1    : err0;
        rdata_s  = sel ? rdata1  : rdata0;
        wr_cnt_s = sel ? wr_cnt1 : wr_cnt0;
        rd_cnt_s = sel ? rd_cnt1 : rd_cnt0;
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // One complete transfer on the selected DUT, with latency, single-pulse
    // and counter checks. Inputs are scrambled right after capture.
    task automatic xfer(input logic s, input logic w, input logic [4:0] a,
                        input logic [31:0] d, input logic [3:0] st,
                        input logic [31:0] er, input logic ee);
        exp_t e;
        int   lat;
        logic got;
        sel = s;
        @(negedge clk);
        wr_rd = w; addr = a; wdata = d; wstrb = st;
        if (s) valid1 = 1'b1; else valid0 = 1'b1;
        q.push_back('{w, er, ee});
        @(posedge clk);
        lat = 0;
        got = 1'b0;
        for (int k = 0; k < 20 && !got; k++) begin
            @(negedge clk);
            if (ready_s) got = 1'b1;
            else chk("rdata_zero_when_not_ready", rdata_s, 32'h0);
            if (k == 0) begin
                valid0 = 1'b0; valid1 = 1'b0;
                wr_rd = ~w; addr = 5'($urandom); wdata = $urandom; wstrb = 4'($urandom);
            end
            if (!got) begin
                @(posedge clk);
                lat++;
            end
        end
        e = q.pop_front();
        if (!got) begin
            chk("ready_timeout", 32'(got), 32'h1);
        end else begin
            chk("latency", 32'(lat), s ? 32'd0 : 32'd2);
            chk("err", 32'(err_s), 32'(e.err));
            if (!e.wr) chk("rdata", rdata_s, e.rdata);
        end
        @(posedge clk);
        @(negedge clk);
        chk("ready_single_pulse", 32'(ready_s), 32'h0);
        if (w) mw[s] = sat_inc(mw[s]); else mr[s] = sat_inc(mr[s]);
        chk("wr_cnt", 32'(wr_cnt_s), 32'(mw[s]));
        chk("rd_cnt", 32'(rd_cnt_s), 32'(mr[s]));
    endtask

    initial begin
        int   np;
        int   offs [3];
        exp_t e;

        offs[0] = 2; offs[1] = 6; offs[2] = 10;
        vecs[0]  = '{1'b1, 5'd3,  32'hDEADBEEF, 4'hF, 32'h0,        1'b0};
        vecs[1]  = '{1'b0, 5'd3,  32'h0,        4'h0, 32'hDEADBEEF, 1'b0};
        vecs[2]  = '{1'b1, 5'd3,  32'h11223344, 4'h5, 32'h0,        1'b0};
        vecs[3]  = '{1'b0, 5'd3,  32'h0,        4'h0, 32'hDE22BE44, 1'b0};
        vecs[4]  = '{1'b1, 5'd4,  32'hA5A5A5A5, 4'hF, 32'h0,        1'b0};
        vecs[5]  = '{1'b1, 5'd20, 32'hFFFFFFFF, 4'hF, 32'h0,        1'b1};
        vecs[6]  = '{1'b0, 5'd4,  32'h0,        4'h0, 32'hA5A5A5A5, 1'b0};
        vecs[7]  = '{1'b0, 5'd20, 32'h0,        4'h0, 32'h0,        1'b1};
        vecs[8]  = '{1'b1, 5'd3,  32'h00000000, 4'h0, 32'h0,        1'b0};
        vecs[9]  = '{1'b0, 5'd3,  32'h0,        4'h0, 32'hDE22BE44, 1'b0};
        vecs[10] = '{1'b1, 5'd15, 32'h01020304, 4'hF, 32'h0,        1'b0};
        vecs[11] = '{1'b1, 5'd15, 32'hCAFEF00D, 4'h8, 32'h0,        1'b0};
        vecs[12] = '{1'b0, 5'd15, 32'h0,        4'h0, 32'hCA020304, 1'b0};
        vecs[13] = '{1'b1, 5'd0,  32'h0BADC0DE, 4'hF, 32'h0,        1'b0};
        vecs[14] = '{1'b1, 5'd16, 32'h12345678, 4'hF, 32'h0,        1'b1};
        vecs[15] = '{1'b0, 5'd16, 32'h0,        4'h0, 32'h0,        1'b1};
        vecs[16] = '{1'b0, 5'd0,  32'h0,        4'h0, 32'h0BADC0DE, 1'b0};

        sel = 1'b0;
        res = 1'b1;
        wr_rd = 1'b0; addr = '0; wdata = '0; wstrb = '0;
        valid0 = 1'b0; valid1 = 1'b0;
        mw[0] = 16'd0; mw[1] = 16'd0; mr[0] = 16'd0; mr[1] = 16'd0;

        repeat (3) @(negedge clk);
        chk("reset_ready",  32'(ready0),  32'h0);
        chk("reset_rdata",  rdata0,       32'h0);
        chk("reset_err",    32'(err0),    32'h0);
        chk("reset_wr_cnt", 32'(wr_cnt0), 32'h0);
        chk("reset_rd_cnt", 32'(rd_cnt0), 32'h0);
        chk("reset_ready1", 32'(ready1),  32'h0);
        res = 1'b0;

        // Table-driven transfers on the wait-state instance.
        for (int i = 0; i < 17; i++) begin
            xfer(1'b0, vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].wstrb,
                 vecs[i].rdata, vecs[i].err);
        end

        // Reset during WAIT of a write drops it completely.
        xfer(1'b0, 1'b1, 5'd5, 32'h55555555, 4'hF, 32'h0, 1'b0);
        sel = 1'b0;
        @(negedge clk);
        wr_rd = 1'b1; addr = 5'd5; wdata = 32'hAAAAAAAA; wstrb = 4'hF; valid0 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        valid0 = 1'b0;
        res = 1'b1;
        #1;
        chk("rst_ready",  32'(ready0),      32'h0);
        chk("rst_state",  32'(dut0.r_state), 32'h0);
        chk("rst_wr_cnt", 32'(wr_cnt0),     32'h0);
        chk("rst_rd_cnt", 32'(rd_cnt0),     32'h0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("rst_no_ready", 32'(ready0), 32'h0);
        end
        res = 1'b0;
        mw[0] = 16'd0; mw[1] = 16'd0; mr[0] = 16'd0; mr[1] = 16'd0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("post_rst_no_ready", 32'(ready0), 32'h0);
        end
        xfer(1'b0, 1'b0, 5'd5, 32'h0, 4'h0, 32'h55555555, 1'b0);

        // Back-to-back reads with valid held high.
        xfer(1'b0, 1'b1, 5'd0, 32'h10101010, 4'hF, 32'h0, 1'b0);
        xfer(1'b0, 1'b1, 5'd1, 32'h20202020, 4'hF, 32'h0, 1'b0);
        xfer(1'b0, 1'b1, 5'd2, 32'h30303030, 4'hF, 32'h0, 1'b0);
        sel = 1'b0;
        q.push_back('{1'b0, 32'h10101010, 1'b0});
        q.push_back('{1'b0, 32'h20202020, 1'b0});
        q.push_back('{1'b0, 32'h30303030, 1'b0});
        @(negedge clk);
        wr_rd = 1'b0; addr = 5'd0; wstrb = 4'h0; valid0 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        begin
            int c0;
            c0 = cyc;
            np = 0;
            for (int k = 0; k < 16; k++) begin
                if (ready0) begin
                    if (np < 3) begin
                        e = q.pop_front();
                        chk("b2b_offset", 32'(cyc - c0), 32'(offs[np]));
                        chk("b2b_rdata",  rdata0,        e.rdata);
                        chk("b2b_err",    32'(err0),     32'h0);
                    end
                    np++;
                    if (np < 3) addr = 5'(np);
                    else valid0 = 1'b0;
                end
                @(negedge clk);
            end
        end
        chk("b2b_pulses", 32'(np), 32'd3);
        q.delete();
        mr[0] = sat_inc(sat_inc(sat_inc(mr[0])));
        chk("b2b_rd_cnt", 32'(rd_cnt0), 32'(mr[0]));
        chk("b2b_wr_cnt", 32'(wr_cnt0), 32'(mw[0]));

        // Zero wait states and read-counter saturation.
        xfer(1'b1, 1'b1, 5'd7, 32'h12345678, 4'hF, 32'h0, 1'b0);
        xfer(1'b1, 1'b0, 5'd7, 32'h0, 4'h0, 32'h12345678, 1'b0);
        @(negedge clk);
        force dut1.r_rd_cnt = 16'hFFFD;
        @(negedge clk);
        release dut1.r_rd_cnt;
        mr[1] = 16'hFFFD;
        xfer(1'b1, 1'b0, 5'd7, 32'h0, 4'h0, 32'h12345678, 1'b0);
        xfer(1'b1, 1'b0, 5'd7, 32'h0, 4'h0, 32'h12345678, 1'b0);
        xfer(1'b1, 1'b0, 5'd7, 32'h0, 4'h0, 32'h12345678, 1'b0);
        chk("sat_rd_cnt", 32'(rd_cnt1), 32'h0000FFFF);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule

// File: doc/mem_ws_slave.md
MEM_WS_SLAVE -- requirements
Module: mem_ws_slave

Interface
REQ-001 SHALL have parameter WIDTH, default 32, data bus width in bits; a multiple of 8.
REQ-002 SHALL have parameter ADDR_WIDTH, default 5, address bus width in bits.
REQ-003 SHALL have parameter DEPTH, default 16, number of words; DEPTH <= 2**ADDR_WIDTH.
REQ-004 SHALL have parameter WAIT_STATES, default 2, wait cycles inserted before ready (0..15).
REQ-005 SHALL have port clk, input, 1, the single clock; all logic on posedge.
REQ-006 SHALL have port res, input, 1, reset, asynchronous, active-high.
REQ-007 SHALL have port wr_rd, input, 1, 1 = write, 0 = read.
REQ-008 SHALL have port addr, input, ADDR_WIDTH, word address.
REQ-009 SHALL have port wdata, input, WIDTH, write data.
REQ-010 SHALL have port wstrb, input, WIDTH/8, byte enables for writes; bit i covers wdata[8i+7:8i].
REQ-011 SHALL have port valid, input, 1, master request valid.
REQ-012 SHALL have port ready, output, 1, transfer completes in the cycle where valid and ready are both high.
REQ-013 SHALL have port rdata, output, WIDTH, read data, meaningful only while ready=1 and wr_rd=0.
REQ-014 SHALL have port err, output, 1, qualified by ready; indicates an out-of-range address.
REQ-015 SHALL have ports wr_cnt and rd_cnt, output, 16 each, completed-transfer counters.

Function
REQ-016 SHALL implement the FSM states IDLE, WAIT and RESP.
REQ-017 In IDLE, valid=1 at a posedge SHALL capture wr_rd, addr, wdata and wstrb, then move to WAIT if WAIT_STATES>0, else to RESP.
REQ-018 In WAIT, a 4-bit counter SHALL load WAIT_STATES-1 on entry, decrement each cycle, and move to RESP at posedge when the count is 0.
REQ-019 In RESP, ready SHALL be 1 for exactly one cycle, and the FSM SHALL return to IDLE at the next posedge; ready SHALL be 0 in all other states.
REQ-020 Latency SHALL be as follows: valid sampled at edge N gives ready high during cycle N+1+WAIT_STATES; throughput is one transfer per 2+WAIT_STATES cycles.
REQ-021 A write SHALL update only the bytes enabled by the captured wstrb, committing at the posedge that ends RESP; wstrb=0 SHALL leave memory unchanged but still complete.
REQ-022 A read SHALL drive rdata in RESP from memory[captured addr], registered on entry to RESP.
REQ-023 If the captured addr >= DEPTH: err=1 in RESP, the write SHALL be discarded, and rdata=0; otherwise err=0.
REQ-024 rdata SHALL be 0 whenever ready=0.
REQ-025 Only captured values SHALL be used; input changes or valid deassertion after capture SHALL NOT abort the transfer, which still completes with one ready pulse.
REQ-026 valid held high across RESP SHALL NOT be re-captured until IDLE, so a back-to-back request is sampled at the first IDLE edge.
REQ-027 wr_cnt and rd_cnt SHALL increment at the RESP-ending edge for writes and reads respectively, including err transfers, and SHALL saturate at 16'hFFFF.
REQ-028 A read of a word written earlier SHALL return the merged post-write value; a read-during-write hazard cannot arise, as there is one transfer in flight.

Reset
REQ-029 res=1 SHALL asynchronously force state=IDLE, the wait counter to 0, ready=0, rdata=0, err=0, wr_cnt=0 and rd_cnt=0.
REQ-030 Memory contents SHALL NOT be reset; a transfer in WAIT or RESP when res asserts SHALL be dropped with no memory write and no counter increment.
REQ-031 After res deasserts, the first posedge SHALL sample valid in IDLE.

Verification (WIDTH=32, ADDR_WIDTH=5, DEPTH=16, WAIT_STATES=2)
REQ-032 Write addr=3, wdata=32'hDEADBEEF, wstrb=4'hF, then read addr=3 -> each ready pulse 3 cycles after capture; rdata=32'hDEADBEEF, err=0; wr_cnt=1, rd_cnt=1.
REQ-033 Write addr=3, wdata=32'h11223344, wstrb=4'b0101 after REQ-032, then read addr=3 -> rdata=32'hDE22BE44.
REQ-034 Write addr=20, wdata=32'hFFFFFFFF -> err=1 during ready, memory unchanged (read of addr=4 unaffected); read addr=20 -> err=1, rdata=0; both counters increment.
REQ-035 Assert res during the WAIT of a write to addr=5 -> ready never pulses, memory[5] is unchanged, counters are 0 and state is IDLE immediately.
REQ-036 Hold valid high for 3 back-to-back reads of addr 0,1,2 -> ready pulses at cycles 3, 7 and 11 after the first capture, with rdata in order; rd_cnt=3.
REQ-037 Preload rd_cnt to saturation via 65536 reads (or force) -> rd_cnt stays 16'hFFFF on the next read; with WAIT_STATES=0, ready follows capture by one cycle.
